// File: rtl/hazard5_shift_iter.sv
`default_nettype none
// ============================================================================
// Module   : hazard5_shift_iter
// Brief    : Iterative log shifter (SLL/SRL/SRA/ROL/ROR), valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module hazard5_shift_iter #(
  parameter int W_DATA           = 32,
  parameter int W_SHAMT          = 5,
  parameter int LAYERS_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W_DATA-1:0]  in_data,
  input  logic [W_SHAMT-1:0] in_shamt,
  input  logic [2:0]         in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W_DATA-1:0]  out_data
);

  localparam int c_n_iter = (W_SHAMT + LAYERS_PER_CYCLE - 1) / LAYERS_PER_CYCLE;
  localparam int c_iter_w = (c_n_iter > 1) ? $clog2(c_n_iter) : 1;
  localparam logic [c_iter_w-1:0] c_last_iter = c_iter_w'(c_n_iter - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t               r_state;
  logic [W_DATA-1:0]    r_accum;
  logic [W_SHAMT-1:0]   r_shamt;
  logic [c_iter_w-1:0]  r_iter;
  logic                 r_rot;
  logic                 r_right;
  logic                 r_fill;
  logic                 r_out_valid;
  logic [W_DATA-1:0]    r_out_data;

  logic [W_DATA-1:0]    w_stage;
  logic [W_SHAMT-1:0]   w_sh_bits;
  int                   w_idx;
  logic                 w_load;
  logic [W_DATA-1:0]    w_load_accum;
  logic                 w_load_fill;

  function automatic logic [W_DATA-1:0] bit_reverse(input logic [W_DATA-1:0] d);
    logic [W_DATA-1:0] r;
    for (int i = 0; i < W_DATA; i++) r[i] = d[W_DATA-1-i];
    return r;
  endfunction

  // Right shifts run as left shifts on the reversed operand, so the fill
  // (zero or sign) always enters at the LSB end.
  function automatic logic [W_DATA-1:0] layer_shift(input logic [W_DATA-1:0] d,
                                                    input int amt,
                                                    input logic rot,
                                                    input logic fill);
    logic [W_DATA-1:0] low_mask;
    low_mask = ~({W_DATA{1'b1}} << amt);
    if (rot) return (d << amt) | (d >> (W_DATA - amt));
    else     return (d << amt) | (fill ? low_mask : '0);
  endfunction

  always_comb begin
    w_stage   = r_accum;
    w_idx     = 0;
    w_sh_bits = '0;
    for (int j = 0; j < LAYERS_PER_CYCLE; j++) begin
      w_idx     = int'(r_iter) * LAYERS_PER_CYCLE + j;
      w_sh_bits = r_shamt >> w_idx;
      if (w_idx < W_SHAMT && w_sh_bits[0])
        w_stage = layer_shift(w_stage, 1 << w_idx, r_rot, r_fill);
    end
  end

  always_comb begin
    case (r_state)
      ST_IDLE: in_ready = 1'b1;
      ST_DONE: in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
  end

  assign w_load       = in_valid && in_ready;
  assign w_load_accum = in_op[0] ? bit_reverse(in_data) : in_data;
  assign w_load_fill  = (in_op == 3'b011) && in_data[W_DATA-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_accum     <= '0;
      r_shamt     <= '0;
      r_iter      <= '0;
      r_rot       <= 1'b0;
      r_right     <= 1'b0;
      r_fill      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_load) r_state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          r_accum <= w_stage;
          r_iter  <= r_iter + 1'b1;
          if (r_iter == c_last_iter) begin
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
            r_out_data  <= r_right ? bit_reverse(w_stage) : w_stage;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= w_load ? ST_SHIFT : ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      if (w_load) begin
        r_accum <= w_load_accum;
        r_shamt <= in_shamt;
        r_iter  <= '0;
        r_rot   <= in_op[2];
        r_right <= in_op[0];
        r_fill  <= w_load_fill;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule
`default_nettype wire
